// File: rtl/multicycle_pkg.sv
// Shared types and encodings for the LEGv8 multi-cycle sequencing controller.
package multicycle_pkg;

    typedef enum logic [2:0] {
        IDLE, FETCH, DECODE, EXEC, MEM, WB, HALTED, ERROR
    } state_t;

    typedef enum logic [3:0] {
        ADDI, ADDS, SUBS, LDUR, STUR, CBZ, B, BLT, HALT, ILLEGAL
    } iclass_t;

    localparam logic [9:0]  OPC_ADDI   = 10'b1001000100;
    localparam logic [10:0] OPC_ADDS   = 11'b10101011000;
    localparam logic [10:0] OPC_SUBS   = 11'b11101011000;
    localparam logic [10:0] OPC_LDUR   = 11'b11111000010;
    localparam logic [10:0] OPC_STUR   = 11'b11111000000;
    localparam logic [7:0]  OPC_CBZ    = 8'b10110100;
    localparam logic [7:0]  OPC_BCOND  = 8'b01010100;
    localparam logic [4:0]  COND_LT    = 5'b01011;
    localparam logic [5:0]  OPC_B      = 6'b000101;
    localparam logic [31:0] INSTR_HALT = 32'hD440_0000;

    localparam logic [2:0] ALU_PASS_B = 3'b000;
    localparam logic [2:0] ALU_ADD    = 3'b010;
    localparam logic [2:0] ALU_SUB    = 3'b011;
    localparam logic [2:0] ALU_AND    = 3'b100;
    localparam logic [2:0] ALU_OR     = 3'b101;
    localparam logic [2:0] ALU_XOR    = 3'b110;

endpackage

// File: rtl/multicycle_seq_ctrl_op_decode.sv
// Combinational instruction classifier on the held instruction word.
module op_decode
    import multicycle_pkg::*;
(
    input  logic [31:0] ir,
    output iclass_t     iclass
);

    // HALT is an exact word match, so it is tested before the opcode fields
    always_comb begin
        iclass = ILLEGAL;
        if (ir == INSTR_HALT)                                  iclass = HALT;
        else if (ir[31:22] == OPC_ADDI)                        iclass = ADDI;
        else if (ir[31:21] == OPC_ADDS)                        iclass = ADDS;
        else if (ir[31:21] == OPC_SUBS)                        iclass = SUBS;
        else if (ir[31:21] == OPC_LDUR)                        iclass = LDUR;
        else if (ir[31:21] == OPC_STUR)                        iclass = STUR;
        else if (ir[31:24] == OPC_CBZ)                         iclass = CBZ;
        else if (ir[31:24] == OPC_BCOND && ir[4:0] == COND_LT) iclass = BLT;
        else if (ir[31:26] == OPC_B)                           iclass = B;
    end

endmodule

// File: rtl/multicycle_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with memory handshakes,
// NZVC flag register, wait-state timeout and retired-instruction counter.
//
// state  | meaning
// IDLE   | one cycle after reset release
// FETCH  | imem_req held until imem_ack; IR loaded on ack
// DECODE | register read, classify IR
// EXEC   | ALU step; branches retire here
// MEM    | dmem_req held until dmem_ack (LDUR/STUR)
// WB     | register write-back, retire
// HALTED | HALT retired, wait for reset
// ERROR  | illegal opcode or memory timeout, wait for reset
module multicycle_seq_ctrl
    import multicycle_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
)(
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instruction,
    output logic             imem_req,
    input  logic             imem_ack,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ack,
    input  logic             zero,
    input  logic             negative,
    input  logic             overflow,
    input  logic             carry_out,
    output logic             ir_load,
    output logic             pc_write,
    output logic             br_taken,
    output logic             uncond_br,
    output logic             reg2loc,
    output logic             alu_src,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic [2:0]       alu_op,
    output logic [3:0]       flags,
    output logic             halted,
    output logic             error,
    output logic [CNT_W-1:0] instr_count
);

    localparam int TMR_W = $clog2(MEM_TIMEOUT + 1);

    state_t           state, state_nxt;
    iclass_t          iclass;
    logic [31:0]      ir;
    logic [TMR_W-1:0] tmr;
    logic             waiting;
    logic             retire;

    op_decode u_op_decode (.ir(ir), .iclass(iclass));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    assign waiting = (state == FETCH && !imem_ack) || (state == MEM && !dmem_ack);
    assign retire  = pc_write || (state == DECODE && iclass == HALT);

    // Wait-state timer reloads whenever no handshake is pending
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ir          <= '0;
            tmr         <= '0;
            flags       <= '0;
            instr_count <= '0;
        end else begin
            if (ir_load) ir <= instruction;
            if (waiting) tmr <= tmr - TMR_W'(1);
            else         tmr <= TMR_W'(MEM_TIMEOUT - 1);
            if (state == EXEC && (iclass == ADDS || iclass == SUBS))
                flags <= {negative, zero, overflow, carry_out};
            if (retire) instr_count <= instr_count + CNT_W'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   state_nxt = FETCH;
            FETCH:  if (imem_ack)        state_nxt = DECODE;
                    else if (tmr == '0)  state_nxt = ERROR;
            DECODE: case (iclass)
                        HALT:    state_nxt = HALTED;
                        ILLEGAL: state_nxt = ERROR;
                        default: state_nxt = EXEC;
                    endcase
            EXEC:   case (iclass)
                        ADDI, ADDS, SUBS: state_nxt = WB;
                        LDUR, STUR:       state_nxt = MEM;
                        CBZ, B, BLT:      state_nxt = FETCH;
                        default:          state_nxt = ERROR;
                    endcase
            MEM:    if (dmem_ack)        state_nxt = (iclass == LDUR) ? WB : FETCH;
                    else if (tmr == '0)  state_nxt = ERROR;
            WB:     state_nxt = FETCH;
            HALTED: state_nxt = HALTED;
            ERROR:  state_nxt = ERROR;
            default: state_nxt = ERROR;
        endcase
    end

    // ALU controls stay valid through MEM and WB so the datapath result is stable
    always_comb begin
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        ir_load    = 1'b0;
        pc_write   = 1'b0;
        br_taken   = 1'b0;
        uncond_br  = 1'b0;
        reg2loc    = 1'b0;
        alu_src    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_op     = ALU_PASS_B;
        halted     = (state == HALTED);
        error      = (state == ERROR);
        if (state == EXEC || state == MEM || state == WB) begin
            case (iclass)
                ADDI:       begin alu_src = 1'b1; alu_op = ALU_ADD; end
                ADDS:       alu_op = ALU_ADD;
                SUBS:       alu_op = ALU_SUB;
                LDUR:       begin alu_src = 1'b1; alu_op = ALU_ADD; end
                STUR:       begin alu_src = 1'b1; alu_op = ALU_ADD; reg2loc = 1'b1; end
                CBZ:        reg2loc = 1'b1;
                default:    alu_op = ALU_PASS_B;
            endcase
        end
        case (state)
            FETCH: begin
                imem_req = 1'b1;
                ir_load  = imem_ack;
            end
            EXEC: begin
                case (iclass)
                    CBZ:     begin pc_write = 1'b1; br_taken = zero; end
                    B:       begin pc_write = 1'b1; br_taken = 1'b1; uncond_br = 1'b1; end
                    BLT:     begin pc_write = 1'b1; br_taken = flags[3] ^ flags[1]; end
                    default: pc_write = 1'b0;
                endcase
            end
            MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (iclass == STUR);
                pc_write = dmem_ack && (iclass == STUR);
            end
            WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (iclass == LDUR);
                pc_write   = 1'b1;
            end
            default: pc_write = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_multicycle_seq_ctrl.sv
// Randomized self-checking bench: per-instruction schedule model vs. DUT handshakes and controls.
module tb_multicycle_seq_ctrl;

    localparam int MEM_TIMEOUT = 16;
    localparam int CNT_W       = 32;

    localparam int C_ADDI = 0, C_ADDS = 1, C_SUBS = 2, C_LDUR = 3, C_STUR = 4;
    localparam int C_CBZ  = 5, C_B    = 6, C_BLT  = 7, C_HALT = 8, C_ILL  = 9;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [31:0]      instruction = '0;
    logic             imem_req, imem_ack = 1'b0;
    logic             dmem_req, dmem_we, dmem_ack = 1'b0;
    logic             zero = 1'b0, negative = 1'b0, overflow = 1'b0, carry_out = 1'b0;
    logic             ir_load, pc_write, br_taken, uncond_br;
    logic             reg2loc, alu_src, mem_to_reg, reg_write;
    logic [2:0]       alu_op;
    logic [3:0]       flags;
    logic             halted, error;
    logic [CNT_W-1:0] instr_count;

    int               n_err = 0;
    int               n_chk = 0;
    logic [3:0]       m_flags = '0;
    logic [CNT_W-1:0] m_count = '0;

    multicycle_seq_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .instruction(instruction),
        .imem_req(imem_req), .imem_ack(imem_ack),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .zero(zero), .negative(negative), .overflow(overflow), .carry_out(carry_out),
        .ir_load(ir_load), .pc_write(pc_write), .br_taken(br_taken), .uncond_br(uncond_br),
        .reg2loc(reg2loc), .alu_src(alu_src), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_op(alu_op), .flags(flags), .halted(halted), .error(error),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] gen_instr(input int cls);
        logic [31:0] r;
        r = $urandom;
        case (cls)
            C_ADDI:  return {10'b1001000100, r[21:0]};
            C_ADDS:  return {11'b10101011000, r[20:0]};
            C_SUBS:  return {11'b11101011000, r[20:0]};
            C_LDUR:  return {11'b11111000010, r[20:0]};
            C_STUR:  return {11'b11111000000, r[20:0]};
            C_CBZ:   return {8'b10110100, r[23:0]};
            C_B:     return {6'b000101, r[25:0]};
            C_BLT:   return {8'b01010100, r[23:5], 5'b01011};
            C_ILL:   return r[31] ? {11'b11111111111, r[20:0]} : {8'b01010100, r[23:5], 5'b00000};
            default: return 32'hD440_0000;
        endcase
    endfunction

    // {alu_op, alu_src, reg2loc} expected while the instruction is retiring
    function automatic logic [4:0] exp_ctl(input int cls);
        case (cls)
            C_ADDI:  return {3'b010, 1'b1, 1'b0};
            C_ADDS:  return {3'b010, 1'b0, 1'b0};
            C_SUBS:  return {3'b011, 1'b0, 1'b0};
            C_LDUR:  return {3'b010, 1'b1, 1'b0};
            C_STUR:  return {3'b010, 1'b1, 1'b1};
            C_CBZ:   return {3'b000, 1'b0, 1'b1};
            default: return 5'b0;
        endcase
    endfunction

    // Asserts rst between clock edges, checks the immediate effect, then releases it.
    task automatic do_reset();
        #1 rst = 1'b0;
        #1;
        chk("rst_outputs", {imem_req, dmem_req, dmem_we, ir_load, pc_write, br_taken, uncond_br,
                            reg2loc, alu_src, mem_to_reg, reg_write, alu_op, flags, halted, error}, 0);
        chk("rst_count", instr_count, 0);
        m_flags = '0;
        m_count = '0;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1 chk("idle_after_rst", imem_req, 0);
    endtask

    // iw/dw: wait cycles before ack (-1 = never). abort>=0: leave after that many MEM cycles.
    task automatic run_instr(input int cls, input logic [31:0] ins, input int iw, input int dw,
                             input logic [3:0] af, input int abort);
        int ireq_n = 0, dreq_n = 0, we_n = 0, irl_n = 0, rw_n = 0;
        int pc_cyc = -1, end_cyc = -1;
        int lat, exp_ireq, exp_dreq, exp_end;
        logic pc_br = 0, pc_unc = 0, pc_rw = 0, pc_m2r = 0;
        logic [4:0] pc_ctl = '0;
        logic e_halt, e_err, e_br;
        bit done = 0;
        bit is_mem = (cls == C_LDUR || cls == C_STUR);
        bit tmo_i = (iw < 0);
        bit tmo_d = is_mem && (dw < 0);
        for (int cyc = 0; cyc < 80 && !done; cyc++) begin
            @(negedge clk);
            {negative, zero, overflow, carry_out} = af;
            imem_ack    = imem_req ? (!tmo_i && ireq_n == iw) : 1'($urandom);
            instruction = (imem_req && imem_ack) ? ins : $urandom;
            dmem_ack    = dmem_req ? (!tmo_d && dreq_n == dw) : 1'($urandom);
            #1;
            if (cyc == 0) chk("fetch_start", imem_req, 1);
            if (imem_req)  ireq_n++;
            if (dmem_req)  dreq_n++;
            if (dmem_we)   we_n++;
            if (ir_load)   irl_n++;
            if (reg_write) rw_n++;
            if (pc_write) begin
                pc_cyc = cyc;
                pc_br  = br_taken;
                pc_unc = uncond_br;
                pc_rw  = reg_write;
                pc_m2r = mem_to_reg;
                pc_ctl = {alu_op, alu_src, reg2loc};
                done   = 1;
            end
            if (halted || error) begin
                end_cyc = cyc;
                done    = 1;
            end
            if (abort >= 0 && dmem_req && dreq_n == abort + 1) return;
        end
        chk("finished", done, 1);

        lat      = (cls == C_CBZ || cls == C_B || cls == C_BLT) ? 3 : (cls == C_LDUR) ? 5 : 4;
        exp_ireq = tmo_i ? MEM_TIMEOUT : iw + 1;
        exp_dreq = (tmo_i || !is_mem) ? 0 : tmo_d ? MEM_TIMEOUT : dw + 1;
        e_halt   = !tmo_i && cls == C_HALT;
        e_err    = tmo_i || tmo_d || cls == C_ILL;
        if (tmo_i)                      exp_end = MEM_TIMEOUT;
        else if (cls >= C_HALT)         exp_end = iw + 2;
        else if (tmo_d)                 exp_end = iw + 3 + MEM_TIMEOUT;
        else                            exp_end = iw + lat - 1 + (is_mem ? dw : 0);

        chk("imem_req_cycles", ireq_n, exp_ireq);
        chk("dmem_req_cycles", dreq_n, exp_dreq);
        chk("ir_load_cycles", irl_n, tmo_i ? 0 : 1);
        chk("dmem_we_cycles", we_n, (cls == C_STUR && !tmo_i) ? exp_dreq : 0);

        if (e_halt || e_err) begin
            chk("end_cycle", end_cyc, exp_end);
            chk("no_pc_write", pc_cyc, -1);
            chk("no_reg_write", rw_n, 0);
            if (e_halt) m_count = m_count + 1'b1;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                imem_ack = 1'($urandom);
                dmem_ack = 1'($urandom);
                #1 chk("sticky", {imem_req, dmem_req, pc_write, halted, error}, {3'b000, e_halt, e_err});
            end
        end else begin
            case (cls)
                C_CBZ:   e_br = af[2];
                C_B:     e_br = 1'b1;
                C_BLT:   e_br = m_flags[3] ^ m_flags[1];
                default: e_br = 1'b0;
            endcase
            chk("pc_write_cycle", pc_cyc, exp_end);
            chk("br_taken", pc_br, e_br);
            chk("uncond_br", pc_unc, cls == C_B);
            chk("reg_write_at_retire", pc_rw, cls <= C_LDUR);
            chk("reg_write_cycles", rw_n, (cls <= C_LDUR) ? 1 : 0);
            chk("mem_to_reg", pc_m2r, cls == C_LDUR);
            chk("alu_ctl", pc_ctl, exp_ctl(cls));
            if (cls == C_ADDS || cls == C_SUBS) m_flags = af;
            m_count = m_count + 1'b1;
        end
        @(posedge clk);
        #1;
        chk("flags", flags, m_flags);
        chk("instr_count", instr_count, m_count);
    endtask

    initial begin
        int r, cls, iw, dw;
        do_reset();

        run_instr(C_ADDI, 32'h9100_0401, 0, 0, 4'b0000, -1);
        run_instr(C_SUBS, gen_instr(C_SUBS), 0, 0, 4'b1001, -1);
        run_instr(C_BLT,  gen_instr(C_BLT),  0, 0, 4'b0000, -1);
        run_instr(C_LDUR, gen_instr(C_LDUR), 1, 3, 4'b0100, -1);
        run_instr(C_CBZ,  gen_instr(C_CBZ),  2, 0, 4'b0100, -1);
        run_instr(C_STUR, gen_instr(C_STUR), 0, -1, 4'b0000, -1);
        do_reset();
        run_instr(C_ILL,  32'h0000_0000, 0, 0, 4'b0000, -1);
        do_reset();
        run_instr(C_ADDS, gen_instr(C_ADDS), 0, 0, 4'b0101, -1);
        run_instr(C_HALT, 32'hD440_0000, 2, 0, 4'b0000, -1);
        do_reset();
        run_instr(C_ADDI, gen_instr(C_ADDI), -1, 0, 4'b0000, -1);
        do_reset();
        run_instr(C_LDUR, gen_instr(C_LDUR), 0, 6, 4'b0000, 2);
        do_reset();

        for (int n = 0; n < 300; n++) begin
            r  = $urandom_range(0, 99);
            iw = $urandom_range(0, 3);
            dw = $urandom_range(0, 4);
            if (r < 88) begin
                cls = $urandom_range(C_ADDI, C_BLT);
                run_instr(cls, gen_instr(cls), iw, dw, 4'($urandom), -1);
            end else begin
                if (r < 91)      cls = C_HALT;
                else if (r < 94) cls = C_ILL;
                else             cls = ($urandom_range(0, 1) != 0) ? C_LDUR : C_STUR;
                if (r == 96)      iw = -1;
                else if (r >= 97) dw = (r == 99) ? 5 : -1;
                run_instr(cls, gen_instr(cls), iw, dw, 4'($urandom), (r == 99) ? 3 : -1);
                do_reset();
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/multicycle_seq_ctrl.md
Name: multicycle_seq_ctrl

Overview:
- Multi-cycle sequencing controller for the LEGv8 CPU datapath.
- Steps each instruction through FETCH / DECODE / EXEC / MEM / WB and handshakes with instruction and data memories that may insert wait states.
- Drives the datapath control lines (Reg2Loc, ALUSrc, ALUOp, MemToReg, RegWrite, MemWrite, BrTaken, UncondBr) and owns the architectural NZVC flag register.
- Sits between instructionPath/dataPath and the memories, replacing single-cycle control.

Parameters:
- MEM_TIMEOUT, 16: max cycles a memory req may wait for ack before entering ERROR.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- instruction  in  32  instruction memory data; valid when imem_ack=1.
- imem_req  out  1  instruction fetch request.
- imem_ack  in  1  fetch complete.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  data memory write (STUR), qualified by dmem_req.
- dmem_ack  in  1  data access complete.
- zero, negative, overflow, carry_out  in  1 each  ALU flags, sampled in EXEC.
- ir_load  out  1  latch instruction into IR.
- pc_write  out  1  PC update strobe.
- br_taken  out  1  select branch target; qualified by pc_write.
- uncond_br  out  1  select imm26 target.
- reg2loc, alu_src, mem_to_reg, reg_write  out  1 each  datapath controls.
- alu_op  out  3  000 pass B, 010 add, 011 sub, 100 and, 101 or, 110 xor.
- flags  out  4  stored {N,Z,V,C}.
- halted  out  1  HALT retired (sticky).
- error  out  1  illegal opcode or memory timeout (sticky).
- instr_count  out  CNT_W  retired instructions.

Behaviour:
- Reset (rst=0, async): state=IDLE. All outputs 0, flags=0, instr_count=0, timeout counter=0. Reset mid-access abandons the access; no handshake completion is required.
- IDLE: one cycle after reset release, then FETCH.
- FETCH:
  - imem_req=1 held until imem_ack.
  - On the ack cycle: ir_load=1, then DECODE.
  - Zero-wait memory means ack in the first FETCH cycle.
- DECODE: one cycle; register-file read. Decode on IR[31:21]:
  - ADDI 1001000100x
  - ADDS 10101011000
  - SUBS 11101011000
  - LDUR 11111000010
  - STUR 11111000000
  - CBZ 10110100xxx
  - B.LT 01010100xxx with IR[4:0]=01011
  - B 000101xxxxx
  - HALT: IR = 32'hD4400000
  - Anything else: ERROR.
- EXEC: alu_op / alu_src / reg2loc per class; all other control outputs are 0 unless listed.
  - ADDI: alu_src=1, alu_op=010.
  - ADDS: alu_op=010; SUBS: alu_op=011. Both load flags ← {negative, zero, overflow, carry_out} at the end of EXEC.
  - LDUR/STUR: alu_src=1, alu_op=010. STUR also reg2loc=1.
  - CBZ: reg2loc=1, alu_op=000; br_taken=zero; pc_write=1; then FETCH.
  - B: uncond_br=1, br_taken=1, pc_write=1; then FETCH.
  - B.LT: br_taken=flags.N ^ flags.V, using the stored flags (not the live ALU flags); pc_write=1; then FETCH.
- MEM (LDUR/STUR):
  - dmem_req=1 held until dmem_ack; dmem_we=1 for STUR.
  - The timeout counter counts waiting cycles; on reaching MEM_TIMEOUT without ack: ERROR.
  - STUR on ack: pc_write=1, then FETCH.
  - LDUR on ack: WB.
  - The same rules apply to imem_req in FETCH.
- WB: reg_write=1 for one cycle; mem_to_reg=1 for LDUR; pc_write=1; then FETCH.
- Retirement:
  - pc_write is asserted exactly once per instruction, on its final cycle.
  - instr_count increments on that same cycle, wrapping modulo 2^CNT_W.
- HALT: in DECODE, go to HALTED. halted=1, instr_count+1, no pc_write. Stay until reset.
- ERROR: error=1, no further requests, stay until reset.
- Latency with zero-wait memory, in cycles from entering FETCH:
  - branches 3
  - ADDI/ADDS/SUBS/STUR 4
  - LDUR 5
- A late ack (ack arriving while req=0) is ignored.

Decomposition:
- Package multicycle_pkg holds:
  - state_t enum: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALTED, ERROR.
  - iclass_t enum: ADDI, ADDS, SUBS, LDUR, STUR, CBZ, B, BLT, HALT, ILLEGAL.
  - Opcode constants and ALUOp constants.
- Sub-module op_decode: combinational IR → iclass_t.
- The FSM, flag register, timeout counter and instr_count stay in the top module.

Test Plan:
- Reset then ADDI (32'h91000401), zero-wait memory → imem_req in cycle 1; reg_write=1 with alu_op=010 and alu_src=1 in cycle 4; pc_write in cycle 4; instr_count=1.
- SUBS with ALU flags N=1, Z=0, V=0, C=1, followed by B.LT → flags=4'b1001; B.LT shows br_taken=1 and pc_write=1 in its EXEC cycle.
- LDUR with dmem_ack delayed 3 cycles → dmem_req high for exactly 4 cycles with dmem_we=0; then WB shows mem_to_reg=1, reg_write=1.
- STUR with dmem_ack never asserted, MEM_TIMEOUT=16 → error=1 after 16 waiting cycles; no pc_write; requests stay 0.
- Undefined opcode 32'h00000000 → ERROR after DECODE, error=1. HALT 32'hD4400000 → halted=1 and instr_count incremented.
- rst driven low mid-MEM (asynchronous, between clock edges) → all outputs 0 immediately; after release, IDLE then FETCH with imem_req=1 on the next cycle.
